// File: rtl/pipe_stage_fifo.sv
// DEPTH-entry valid/ready buffer carrying {PC, instruction} between pipeline stages.
// Define PIPE_BYPASS_EN for a zero-latency path when the buffer is empty.
module pipe_stage_fifo #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       PC_in,
  input  logic [DATA_W-1:0]       instr_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ADDR_W-1:0]       PC_out,
  output logic [DATA_W-1:0]       instr_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    stall,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_open;
  logic             w_byp;
  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_open  = !stall && !flush;

`ifdef PIPE_BYPASS_EN
  assign w_byp = w_empty && in_valid && w_open;
`else
  assign w_byp = 1'b0;
`endif

  // Head entry, or the live input when bypassing an empty buffer
  always_comb begin
    w_head = '0;
    if (!w_empty) begin
      w_head = r_mem[r_rd_ptr];
    end else if (w_byp) begin
      w_head = {PC_in, instr_in};
    end
  end

  assign {PC_out, instr_out} = w_head;
  assign in_ready  = !w_full && w_open;
  assign out_valid = (!w_empty && w_open) || w_byp;

  // A bypassed beat that is consumed immediately never touches storage
  assign w_pop  = out_valid && out_ready && !w_empty;
  assign w_push = in_valid && in_ready && !(w_byp && out_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset; only slots between rd_ptr and wr_ptr are ever read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {PC_in, instr_in};
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Scoreboard bench for pipe_stage_fifo: a bounded queue model predicts
// acceptance, occupancy and delivered payloads under directed and random traffic.
module tb_pipe_stage_fifo;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

`ifdef PIPE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] PC_in = '0;
  logic [DW-1:0] instr_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] PC_out;
  logic [DW-1:0] instr_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  bit in_reset = 1'b1;
  logic [AW+DW-1:0] exp_q [$];

  pipe_stage_fifo #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .PC_in(PC_in), .instr_in(instr_in),
    .in_valid(in_valid), .in_ready(in_ready), .PC_out(PC_out),
    .instr_out(instr_out), .out_valid(out_valid), .out_ready(out_ready),
    .stall(stall), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented head against the model, pops on handshake
  initial begin
    logic             byp;
    logic             exp_v;
    logic [AW+DW-1:0] exp_d;
    forever begin
      @(negedge clk);
      #1;
      if (!in_reset) begin
        byp   = BYP && (exp_q.size() == 0) && in_valid && !stall && !flush;
        exp_v = ((exp_q.size() != 0) && !stall && !flush) || byp;
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_q.size() != 0)  exp_d = exp_q[0];
        else if (byp)           exp_d = {PC_in, instr_in};
        else                    exp_d = '0;
        chk("payload", {PC_out, instr_out}, exp_d);
        if (exp_v && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  // Driver: issues one cycle of stimulus and updates the model with what must be accepted
  task automatic cyc(input logic iv, input logic [AW-1:0] pc, input logic [DW-1:0] ins,
                     input logic ordy, input logic st, input logic fl);
    int   occ;
    logic exp_rdy;
    logic byp;
    @(negedge clk);
    in_valid = iv; PC_in = pc; instr_in = ins;
    out_ready = ordy; stall = st; flush = fl;
    occ = exp_q.size();
    #2;
    exp_rdy = (occ < int'(DEPTH)) && !st && !fl;
    byp     = BYP && (occ == 0) && iv && !st && !fl;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("count", 64'(count), 64'(occ));
    if (fl) exp_q.delete();
    else if (iv && exp_rdy && !(byp && ordy)) exp_q.push_back({pc, ins});
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_reset = 1'b1; reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset = 1'b1; in_reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_pc_out", 64'(PC_out), 64'(0));
  endtask

  initial begin
    do_reset();

    // Fill to full; third push must be refused
    cyc(1'b1, 32'h100, 32'hA0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h104, 32'hA1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h108, 32'hA2, 1'b0, 1'b0, 1'b0);
    // Drain from full
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    // Streaming push+pop
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    // Stall holds a full buffer, then flush overrides stall
    cyc(1'b1, 32'h400, 32'hC0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h404, 32'hC1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h500, 32'hC2, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    // Flush blocks a same-cycle push; then an input on an empty buffer
    cyc(1'b1, 32'h300, 32'hD0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h300, 32'hD0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional stall, flush and mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom,
          $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
          $urandom_range(0, 19) == 0);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
